// File: rtl/alu_issue.sv
// ALU issue and writeback controller.
// Two-stage pipeline. ISS holds the operands on alu_*, and the external ALU
// registers its result at the end of ISS. WB then writes alu_out into the
// register file and, when the instruction asked for it, alu_flags into the
// flags register. A source operand that matches the WB destination is taken
// from alu_out. A source operand that matches the ISS destination stalls
// issue for one cycle, because that result does not exist yet.
module alu_issue (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_rd,
  input  logic [2:0] in_rs1,
  input  logic [2:0] in_rs2,
  input  logic [2:0] in_op,
  input  logic [2:0] in_shamt,
  input  logic       in_fw,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic [2:0] alu_shamt,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags,
  input  logic [2:0] dbg_sel,
  output logic [7:0] dbg_data,
  output logic       busy
);

  logic [7:0] regs [8];

  logic       iss_valid;
  logic [2:0] iss_rd;
  logic       iss_fw;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic       wb_fw;

  logic       accept;
  logic [7:0] opa;
  logic [7:0] opb;

  // Load-use stall: the ISS result is not available yet. This depends only on ISS state and the source indices.
  always_comb begin
    in_ready = !(iss_valid && ((iss_rd == in_rs1) || (iss_rd == in_rs2)));
  end

  assign accept = in_valid && in_ready;

  // Operand select: the WB result is newer than the register file.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    opa = regs[in_rs1];
    opb = regs[in_rs2];
    if (wb_valid && (wb_rd == in_rs1)) opa = alu_out;
    if (wb_valid && (wb_rd == in_rs2)) opb = alu_out;
  end

  // ISS stage: capture the operands on acceptance and hold them otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples its pre-edge inputs.
      iss_valid <= 1'b0;
      iss_rd    <= '0;
      iss_fw    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_shamt <= '0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss_rd    <= in_rd;
        iss_fw    <= in_fw;
        alu_a     <= opa;
        alu_b     <= opb;
        alu_op    <= in_op;
        alu_shamt <= in_shamt;
      end
    end
  end

  // WB stage: follows ISS by one cycle while the ALU produces its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_fw    <= 1'b0;
    end else begin
      wb_valid <= iss_valid;
      wb_rd    <= iss_rd;
      wb_fw    <= iss_fw;
    end
  end

  // Architectural state: write the register file and the gated flags at the end of WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is cleared by reset because software relies on r0-r7 reading 0x00; this keeps it in flops rather than RAM.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      flags <= '0;
    end else if (wb_valid) begin
      regs[wb_rd] <= alu_out;
      if (wb_fw) flags <= alu_flags;
    end
  end

  assign dbg_data = regs[dbg_sel];
  assign busy     = iss_valid || wb_valid;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue.
// A sequential register-file model supplies the expected operands for each
// accepted instruction. An ALU stub returns the result that the bench chose
// for that instruction. A monitor compares operands, flags, busy and
// written-back values as they appear.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_rd, in_rs1, in_rs2, in_op, in_shamt;
  logic       in_fw;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op, alu_shamt;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic [3:0] flags;
  logic [2:0] dbg_sel;
  logic [7:0] dbg_data;
  logic       busy;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_op(in_op),
    .in_shamt(in_shamt), .in_fw(in_fw), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_out(alu_out),
    .alu_flags(alu_flags), .flags(flags), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [2:0] sh;
  } iss_t;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
    logic [3:0] fl;
  } wb_t;

  iss_t        iss_q[$];
  wb_t         wb_q[$];
  logic [11:0] res_q[$];

  logic [7:0] mreg [8];
  logic [3:0] mflags;
  logic [2:0] last_rd;
  bit         drv_acc = 1'b0;
  bit         hs_d1 = 1'b0, hs_d2 = 1'b0, hs_d3 = 1'b0;
  bit         mon_dbg = 1'b1;
  logic [2:0] mon_sel = '0;
  logic [2:0] drv_sel = '0;
  iss_t       last_iss = '{default: '0};

  int checks = 0;
  int errors = 0;

  assign dbg_sel = mon_dbg ? mon_sel : drv_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ALU stub: one cycle after an acceptance, return the result the bench chose for it.
  always @(posedge clk) begin : stub
    logic [11:0] r;
    if (rst) begin
      hs_d1 <= 1'b0;
      hs_d2 <= 1'b0;
      hs_d3 <= 1'b0;
    end else begin
      if (hs_d1 && res_q.size() > 0) begin
        r = res_q.pop_front();
        alu_out   <= r[11:4];
        alu_flags <= r[3:0];
      end
      hs_d1 <= drv_acc;
      hs_d2 <= hs_d1;
      hs_d3 <= hs_d2;
    end
  end

  // Monitor: operands one cycle after acceptance, architectural state after writeback.
  always @(negedge clk) begin : monitor
    wb_t w;
    if (rst) begin
      last_iss = '{default: '0};
    end else begin
      check("busy", busy, hs_d1 | hs_d2);
      if (hs_d1) begin
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL iss_queue_empty t=%0t", $time);
        end else begin
          last_iss = iss_q.pop_front();
        end
      end
      check("alu_a", alu_a, last_iss.a);
      check("alu_b", alu_b, last_iss.b);
      check("alu_op", alu_op, last_iss.op);
      check("alu_shamt", alu_shamt, last_iss.sh);
      if (hs_d3) begin
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_queue_empty t=%0t", $time);
        end else begin
          w = wb_q.pop_front();
          check("flags_after_wb", flags, w.fl);
          if (mon_dbg) begin
            mon_sel = w.rd;
            #1;
            check("reg_after_wb", dbg_data, w.val);
          end
        end
      end
    end
  end

  // One cycle of stimulus. The model updates in program order on acceptance.
  task automatic drive(input bit v, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [2:0] op, input logic [2:0] sh,
                       input bit fw, input logic [7:0] res, input logic [3:0] fl,
                       output bit acc);
    logic exp_rdy;
    @(negedge clk);
    in_valid = v; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_op = op; in_shamt = sh; in_fw = fw;
    #1;
    exp_rdy = !(hs_d1 && ((last_rd == rs1) || (last_rd == rs2)));
    check("in_ready", in_ready, exp_rdy);
    acc = v && in_ready;
    drv_acc = acc;
    if (acc) begin
      iss_q.push_back('{a: mreg[rs1], b: mreg[rs2], op: op, sh: sh});
      res_q.push_back({res, fl});
      mreg[rd] = res;
      if (fw) mflags = fl;
      wb_q.push_back('{rd: rd, val: res, fl: mflags});
      last_rd = rd;
    end
  endtask

  task automatic idle();
    bit acc;
    drive(1'b0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
          1'b0, 8'h00, 4'h0, acc);
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input bit fw, input logic [7:0] res, input logic [3:0] fl,
                       output int stalls);
    bit acc = 1'b0;
    logic [2:0] op = 3'($urandom);
    logic [2:0] sh = 3'($urandom);
    stalls = 0;
    for (int t = 0; t < 4 && !acc; t++) begin
      drive(1'b1, rd, rs1, rs2, op, sh, fw, res, fl, acc);
      if (!acc) stalls++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout rd=%0d stalls=%0d t=%0t", rd, stalls, $time);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) idle();
  endtask

  task automatic dump_regs(input string tag);
    mon_dbg = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_sel = 3'(i);
      #1;
      check({tag, "_reg"}, dbg_data, mreg[i]);
    end
    check({tag, "_flags"}, flags, mflags);
    mon_dbg = 1'b1;
  endtask

  task automatic clear_model();
    iss_q.delete();
    wb_q.delete();
    res_q.delete();
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mflags = 4'h0;
    last_rd = 3'd0;
  endtask

  // Assert reset between edges and check that the clear is immediate.
  task automatic do_reset();
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    drv_acc = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_flags", flags, 4'h0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", {alu_op, alu_shamt}, 6'h00);
    mon_dbg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv_sel = 3'(i);
      #1;
      check("rst_dbg", dbg_data, 8'h00);
    end
    mon_dbg = 1'b1;
    clear_model();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : main
    int st, tot;
    rst = 1'b1;
    in_valid = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_op = '0; in_shamt = '0; in_fw = 1'b0;
    alu_out = '0; alu_flags = '0;
    clear_model();
    #1;
    check("init_busy", busy, 1'b0);
    check("init_flags", flags, 4'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Independent back-to-back issue.
    tot = 0;
    issue(3'd1, 3'd5, 3'd6, 1'b0, 8'h11, 4'h0, st); tot += st;
    issue(3'd2, 3'd6, 3'd7, 1'b0, 8'h22, 4'h0, st); tot += st;
    issue(3'd3, 3'd7, 3'd0, 1'b0, 8'h33, 4'h0, st); tot += st;
    issue(3'd4, 3'd0, 3'd5, 1'b0, 8'h44, 4'h0, st); tot += st;
    check("indep_stalls", tot, 0);
    drain();
    dump_regs("indep");

    // Load-use stall followed by forwarding from WB.
    issue(3'd2, 3'd3, 3'd4, 1'b0, 8'h5A, 4'h0, st);
    issue(3'd7, 3'd2, 3'd1, 1'b0, 8'h66, 4'h0, st);
    check("loaduse_stalls", st, 1);
    idle();
    check("loaduse_alu_a", alu_a, 8'h5A);
    drain();

    // Flag update gating.
    issue(3'd1, 3'd2, 3'd3, 1'b1, 8'h01, 4'hA, st);
    issue(3'd4, 3'd5, 3'd6, 1'b0, 8'h02, 4'h5, st);
    drain();
    check("flags_gated", flags, 4'hA);
    drain();
    check("flags_hold", flags, 4'hA);

    // Debug read while WB writes the selected register.
    issue(3'd3, 3'd1, 3'd2, 1'b0, 8'h10, 4'h0, st);
    drain();
    mon_dbg = 1'b0;
    issue(3'd3, 3'd1, 3'd2, 1'b0, 8'h7E, 4'h0, st);
    idle();
    idle();
    drv_sel = 3'd3;
    #1;
    check("dbg_old", dbg_data, 8'h10);
    idle();
    check("dbg_new", dbg_data, 8'h7E);
    mon_dbg = 1'b1;
    drain();

    // Forward the WB value to both operands.
    tot = 0;
    issue(3'd5, 3'd1, 3'd2, 1'b0, 8'hC3, 4'h0, st); tot += st;
    issue(3'd0, 3'd1, 3'd2, 1'b0, 8'h01, 4'h0, st); tot += st;
    issue(3'd6, 3'd5, 3'd5, 1'b0, 8'h99, 4'h0, st); tot += st;
    check("dual_stalls", tot, 0);
    idle();
    check("dual_alu_a", alu_a, 8'hC3);
    check("dual_alu_b", alu_b, 8'hC3);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) != 0)
        issue(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
              8'($urandom), 4'($urandom), st);
      else
        idle();
    end
    drain();
    dump_regs("random");

    // Reset with two instructions in flight.
    issue(3'd1, 3'd2, 3'd3, 1'b1, 8'hEE, 4'hF, st);
    issue(3'd4, 3'd5, 3'd6, 1'b1, 8'hDD, 4'hE, st);
    do_reset();
    idle();
    drain();
    dump_regs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
